// File: rtl/rs232_avalon_slave.sv
// rs232_avalon_slave: Avalon-MM slave 8N1 UART with RX data @0, TX data @4 and STATUS @8.
module rs232_avalon_slave #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF1 = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t        r_rx_state, r_tx_state;
  logic          r_busy, r_rx_s1, r_rx_s2, r_rx_s3, r_rx_ready, r_ovr, r_ferr, r_txd;
  logic [31:0]   r_rdata;
  logic [CW-1:0] r_rx_cnt, r_tx_cnt;
  logic [2:0]    r_rx_idx, r_tx_idx;
  logic [7:0]    r_rx_shift, r_rx_data, r_tx_shift;
  logic          w_req, w_rd, w_wr, w_rx_clr, w_stat_clr, w_tx_ready, w_tx_load, w_rx_done, w_rx_good;
  logic [7:0]    w_status;
  logic [31:0]   w_rd_mux;
  assign w_req           = avs_read | avs_write;
  assign avs_waitrequest = w_req & ~r_busy;
  assign w_rd            = r_busy & avs_read;
  assign w_wr            = r_busy & avs_write & ~avs_read;
  assign w_rx_clr        = w_rd & (avs_address == 5'd0);
  assign w_stat_clr      = w_rd & (avs_address == 5'd8);
  assign w_tx_ready      = r_tx_state == S_IDLE;
  assign w_tx_load       = w_wr & (avs_address == 5'd4) & w_tx_ready;
  assign w_rx_done       = (r_rx_state == S_STOP) && (r_rx_cnt == LAST);
  assign w_rx_good       = w_rx_done & r_rx_s2;
  assign w_status        = {r_rx_ready, w_tx_ready, r_ovr, r_ferr, 4'b0};
  assign w_rd_mux        = avs_address == 5'd0 ? {24'b0, r_rx_data} :
                           avs_address == 5'd8 ? {24'b0, w_status} : 32'b0;
  assign avs_readdata    = r_rdata;
  assign uart_txd        = r_txd;
  // readdata is captured in the request cycle; side effects land at the completing edge
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_busy     <= 1'b0;
      r_rdata    <= 32'b0;
      r_rx_ready <= 1'b0;
      r_rx_data  <= 8'b0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_busy     <= w_req & ~r_busy;
      if (avs_read & ~r_busy) r_rdata <= w_rd_mux;
      r_rx_ready <= w_rx_good | (r_rx_ready & ~w_rx_clr);
      if (w_rx_good) r_rx_data <= r_rx_shift;
      r_ovr      <= (w_rx_good & r_rx_ready & ~w_rx_clr) | (r_ovr & ~w_stat_clr);
      r_ferr     <= (w_rx_done & ~r_rx_s2) | (r_ferr & ~w_stat_clr);
    end
  end
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      {r_rx_s1, r_rx_s2, r_rx_s3} <= 3'b111;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= 3'd0;
      r_rx_shift <= 8'b0;
    end else begin
      {r_rx_s1, r_rx_s2, r_rx_s3} <= {uart_rxd, r_rx_s1, r_rx_s2};
      case (r_rx_state)
        S_IDLE: if (r_rx_s3 & ~r_rx_s2) begin
          r_rx_state <= S_START;
          r_rx_cnt   <= '0;
        end
        S_START: if (r_rx_cnt == HALF1) begin
          r_rx_cnt   <= '0;
          r_rx_idx   <= 3'd0;
          r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
        end else r_rx_cnt <= r_rx_cnt + CW'(1);
        S_DATA: if (r_rx_cnt == LAST) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_idx   <= r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) r_rx_state <= S_STOP;
        end else r_rx_cnt <= r_rx_cnt + CW'(1);
        default: if (r_rx_cnt == LAST) begin
          r_rx_cnt   <= '0;
          r_rx_state <= S_IDLE;
        end else r_rx_cnt <= r_rx_cnt + CW'(1);
      endcase
    end
  end
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= 3'd0;
      r_tx_shift <= 8'b0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: if (w_tx_load) begin
          r_tx_shift <= 8'(avs_writedata);
          r_txd      <= 1'b0;
          r_tx_cnt   <= '0;
          r_tx_state <= S_START;
        end
        S_START: if (r_tx_cnt == LAST) begin
          r_tx_cnt   <= '0;
          r_tx_idx   <= 3'd0;
          r_txd      <= r_tx_shift[0];
          r_tx_state <= S_DATA;
        end else r_tx_cnt <= r_tx_cnt + CW'(1);
        S_DATA: if (r_tx_cnt == LAST) begin
          r_tx_cnt <= '0;
          if (r_tx_idx == 3'd7) begin
            r_txd      <= 1'b1;
            r_tx_state <= S_STOP;
          end else begin
            r_tx_idx   <= r_tx_idx + 3'd1;
            r_txd      <= r_tx_shift[1];
            r_tx_shift <= r_tx_shift >> 1;
          end
        end else r_tx_cnt <= r_tx_cnt + CW'(1);
        default: if (r_tx_cnt == LAST) begin
          r_tx_cnt   <= '0;
          r_tx_state <= S_IDLE;
        end else r_tx_cnt <= r_tx_cnt + CW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_rs232_avalon_slave.sv
// tb_rs232_avalon_slave: directed/randomised bench for the Avalon UART slave against a register-level model.
module tb_rs232_avalon_slave;
  localparam int CPB = 16;
  logic        clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0, rxd = 1'b1;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wdata = 32'b0;
  logic [31:0] rdata;
  logic        wait_req, txd;
  int          checks = 0, failures = 0;
  bit          m_rx_ready = 0, m_tx_ready = 1, m_ovr = 0, m_ferr = 0;
  logic [7:0]  m_rx_data = 8'h00;
  always #5 clk = ~clk;
  rs232_avalon_slave #(.CLKS_PER_BIT(CPB)) dut (
    .avm_clk(clk), .avm_rst_n(rst_n), .avs_address(addr), .avs_read(rd),
    .avs_readdata(rdata), .avs_write(wr), .avs_writedata(wdata),
    .avs_waitrequest(wait_req), .uart_rxd(rxd), .uart_txd(txd));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] m_status();
    return {24'b0, m_rx_ready, m_tx_ready, m_ovr, m_ferr, 4'b0};
  endfunction
  function automatic logic tx_bit(input logic [7:0] b, input int k);
    int n;
    n = k / CPB;
    return n == 0 ? 1'b0 : n == 9 ? 1'b1 : b[n-1];
  endfunction
  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output int w);
    @(negedge clk); addr = a; rd = 1'b1; #1; w = 0;
    while (wait_req === 1'b1 && w < 8) begin w++; @(posedge clk); #1; end
    d = rdata;
    @(posedge clk); #1; rd = 1'b0;
  endtask
  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input string tag);
    int w;
    @(negedge clk); addr = a; wdata = d; wr = 1'b1; #1; w = 0;
    while (wait_req === 1'b1 && w < 8) begin w++; @(posedge clk); #1; end
    chk({tag, "_wait"}, 32'(w), 32'd1);
    @(posedge clk); #1; wr = 1'b0;
  endtask
  task automatic rd_chk(input logic [4:0] a, input string tag);
    logic [31:0] d, e;
    int w;
    e = a == 5'd0 ? {24'b0, m_rx_data} : a == 5'd8 ? m_status() : 32'b0;
    bus_rd(a, d, w);
    chk(tag, d, e);
    chk({tag, "_wait"}, 32'(w), 32'd1);
    if (a == 5'd0) m_rx_ready = 0;
    if (a == 5'd8) begin m_ovr = 0; m_ferr = 0; end
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    @(negedge clk); rxd = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (CPB) @(negedge clk); end
    rxd = stop_ok; repeat (CPB) @(negedge clk);
    rxd = 1'b1; repeat (2 * CPB) @(negedge clk);
    if (stop_ok) begin
      if (m_rx_ready) m_ovr = 1;
      m_rx_data = b;
      m_rx_ready = 1;
    end else m_ferr = 1;
  endtask
  initial begin
    logic [7:0] b, b2;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_wait", 32'(wait_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd_chk(5'd8, "reset_status");
    rd_chk(5'(4 * $urandom_range(3, 7)), "undecoded_rd");
    bus_wr(5'd0, $urandom, "wr_rx_ignored");
    rd_chk(5'd8, "after_ignored_wr");
    for (int i = 0; i < 3; i++) begin
      b = i == 0 ? 8'hA5 : 8'($urandom);
      send_frame(b, 1'b1);
      rd_chk(5'd8, "rx_status");
      rd_chk(5'd0, "rx_data");
      rd_chk(5'd8, "rx_status_clr");
    end
    bus_wr(5'd4, {24'($urandom), 8'h3C}, "tx_a");
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k % CPB == 0 || k % CPB == CPB - 1) chk($sformatf("txd_k%0d", k), 32'(txd), 32'(tx_bit(8'h3C, k)));
      @(posedge clk); #1;
    end
    chk("txd_idle_after", 32'(txd), 32'd1);
    rd_chk(5'd8, "tx_ready_after_a");
    b = 8'($urandom);
    bus_wr(5'd4, {24'b0, b}, "tx_b");
    m_tx_ready = 0;
    rd_chk(5'd8, "tx_busy");
    bus_wr(5'd4, 32'h55, "tx_drop");
    repeat (155) @(posedge clk);
    #1;
    rd_chk(5'd8, "tx_busy_last");
    m_tx_ready = 1;
    rd_chk(5'd8, "tx_ready_back");
    b = 8'($urandom);
    b2 = 8'($urandom);
    send_frame(b, 1'b1);
    send_frame(b2, 1'b1);
    rd_chk(5'd0, "ovr_data");
    rd_chk(5'd8, "ovr_status");
    rd_chk(5'd8, "ovr_clr");
    send_frame(8'($urandom), 1'b0);
    rd_chk(5'd8, "ferr_status");
    rd_chk(5'd8, "ferr_clr");
    @(negedge clk); rxd = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rd_chk(5'd8, "glitch_status");
    send_frame(8'($urandom), 1'b1);
    rd_chk(5'd0, "post_glitch_data");
    rd_chk(5'd8, "post_glitch_status");
    bus_wr(5'd4, 32'h0, "tx_rst");
    @(negedge clk); rxd = 1'b0;
    repeat (40) @(negedge clk);
    chk("txd_before_rst", 32'(txd), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("txd_in_rst", 32'(txd), 32'd1);
    chk("rdata_in_rst", rdata, 32'd0);
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    rst_n = 1'b1;
    m_rx_ready = 0; m_ovr = 0; m_ferr = 0; m_tx_ready = 1; m_rx_data = 8'h00;
    repeat (2 * CPB) @(negedge clk);
    chk("txd_after_rst", 32'(txd), 32'd1);
    rd_chk(5'd8, "post_reset_status");
    send_frame(8'($urandom), 1'b1);
    rd_chk(5'd0, "post_reset_data");
    rd_chk(5'd8, "post_reset_status2");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
